// File: rtl/aqp_ovl_text_fetch.sv
// Overlay text fetch: per line, reads char/attr then glyph bytes into a double-buffered line buffer, shifts out pixels.
// Latency: 4 cycles per column fetch, 1 cycle pix_en->pix_color; no backpressure (RAM ports always ready, pix_en paces output).
module aqp_ovl_text_fetch #(
  parameter int COLUMNS = 40,
  parameter int ROWS    = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  vline,
  output logic [10:0] text_addr,
  input  logic [15:0] text_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        fetch_busy,
  input  logic        pix_start,
  input  logic        pix_en,
  output logic [3:0]  pix_color,
  output logic        pix_active
);

  localparam int AW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int CW = $clog2(COLUMNS + 1);
  localparam logic [8:0] BLANK_FROM = 9'(ROWS * 8);

  typedef enum logic [2:0] {S_IDLE, S_TADDR, S_TWAIT, S_FADDR, S_FDATA} state_t;

  state_t        state_q, state_d;
  logic [7:0]    vline_q;
  logic [AW-1:0] fc;
  logic [3:0]    fg, bg;
  logic          sel;
  logic [1:0]    blank;
  logic [15:0]   lbuf [2][COLUMNS];
  logic [CW-1:0] dcol;
  logic [2:0]    dbit;
  logic [15:0]   ent;
  logic [7:0]    pat;
  logic          vis;
  logic          last_col;
  logic [10:0]   row_base;

  assign vis        = {1'b0, vline} < BLANK_FROM;
  assign last_col   = (fc == AW'(COLUMNS - 1));
  assign row_base   = 11'(vline_q[7:3]) * 11'(COLUMNS);
  assign fetch_busy = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_TADDR: state_d = S_TWAIT;
      S_TWAIT: state_d = S_FADDR;
      S_FADDR: state_d = S_FDATA;
      S_FDATA: state_d = last_col ? S_IDLE : S_TADDR;
      default: state_d = S_IDLE;
    endcase
    // A new line always wins, aborting whatever fetch is in flight.
    if (line_start) state_d = vis ? S_TADDR : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      text_addr <= '0;
      font_addr <= '0;
      vline_q   <= '0;
      fc        <= '0;
      fg        <= '0;
      bg        <= '0;
      sel       <= 1'b0;
      blank     <= 2'b11;
    end else begin
      state_q <= state_d;
      if (line_start) begin
        // sel is the display bank; the old display bank becomes the fetch target.
        sel        <= ~sel;
        blank[sel] <= ~vis;
        vline_q    <= vline;
        fc         <= '0;
      end else begin
        case (state_q)
          S_TADDR: text_addr <= row_base + 11'(fc);
          S_FADDR: begin
            font_addr <= {text_data[7:0], vline_q[2:0]};
            fg        <= text_data[15:12];
            bg        <= text_data[11:8];
          end
          S_FDATA: if (!last_col) fc <= fc + AW'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!line_start && state_q == S_FDATA) lbuf[~sel][fc] <= {fg, bg, font_data};
  end

  assign ent = lbuf[sel][dcol[AW-1:0]];
  assign pat = ent[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      dcol       <= '0;
      dbit       <= '0;
      pix_color  <= '0;
      pix_active <= 1'b0;
    end else if (pix_start) begin
      dcol <= '0;
      dbit <= '0;
    end else if (pix_en) begin
      if (dcol < CW'(COLUMNS) && !blank[sel]) begin
        pix_color  <= pat[~dbit] ? ent[15:12] : ent[11:8];
        pix_active <= 1'b1;
        dbit       <= dbit + 3'd1;
        if (dbit == 3'd7) dcol <= dcol + CW'(1);
      end else begin
        pix_color  <= '0;
        pix_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aqp_ovl_text_fetch.sv
// Bench for aqp_ovl_text_fetch: random RAM contents, pixels predicted from text/font arrays.
module tb_aqp_ovl_text_fetch;

  localparam int COLUMNS = 40;
  localparam int ROWS    = 25;
  localparam int NPIX    = COLUMNS * 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [7:0]  vline;
  logic [10:0] text_addr;
  logic [15:0] text_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        fetch_busy;
  logic        pix_start;
  logic        pix_en;
  logic [3:0]  pix_color;
  logic        pix_active;

  always #5 clk = ~clk;

  aqp_ovl_text_fetch #(.COLUMNS(COLUMNS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .vline(vline),
    .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data),
    .fetch_busy(fetch_busy), .pix_start(pix_start), .pix_en(pix_en),
    .pix_color(pix_color), .pix_active(pix_active)
  );

  // RAMs return data for the registered address in the following cycle.
  logic [15:0] tram [2048];
  logic [7:0]  fram [2048];
  assign text_data = tram[text_addr];
  assign font_data = fram[font_addr];

  typedef struct {
    int v;
    int ncols;
    bit blank;
  } line_t;

  line_t      disp_l, pend_l;
  logic [3:0] last_color;
  logic       last_active;
  int         nvec = 0;
  int         nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] exp_px(input int p);
    logic [10:0] ta;
    logic [15:0] w;
    logic [7:0]  pt;
    logic [2:0]  b;
    if (disp_l.blank || p >= NPIX) return 5'd0;
    ta = 11'((disp_l.v / 8) * COLUMNS + p / 8);
    w  = tram[ta];
    pt = fram[{w[7:0], 3'(disp_l.v % 8)}];
    b  = 3'(7 - p % 8);
    return {1'b1, pt[b] ? w[15:12] : w[11:8]};
  endfunction

  task automatic model_reset();
    disp_l.v = 0; disp_l.ncols = COLUMNS; disp_l.blank = 1'b1;
    pend_l = disp_l;
    last_color = 4'd0;
    last_active = 1'b0;
  endtask

  // Issues line_start for v and follows the fetch; abort_at>0 returns in that cycle of the fetch.
  task automatic run_fetch(input int v, input int abort_at);
    logic [10:0] ta0, fa0;
    logic [15:0] w;
    int busy_cnt, row, c;
    bit vis;
    vis = (v < ROWS * 8);
    row = v / 8;
    ta0 = text_addr;
    fa0 = font_addr;
    disp_l = pend_l;
    pend_l.v = v; pend_l.ncols = COLUMNS; pend_l.blank = !vis;
    vline = 8'(v);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    if (!vis) begin
      for (int k = 0; k < 4; k++) begin
        chk("blank_busy", fetch_busy, 0);
        chk("blank_taddr", text_addr, ta0);
        chk("blank_faddr", font_addr, fa0);
        step();
      end
      return;
    end
    busy_cnt = 0;
    for (int j = 1; j <= 4 * COLUMNS + 40; j++) begin
      if (fetch_busy) busy_cnt++;
      if (j <= 4 * COLUMNS && j % 4 == 2)
        chk("text_addr", text_addr, 11'(row * COLUMNS + (j - 2) / 4));
      if (j <= 4 * COLUMNS && j % 4 == 0) begin
        c = (j - 4) / 4;
        w = tram[11'(row * COLUMNS + c)];
        chk("font_addr", font_addr, {w[7:0], 3'(v % 8)});
      end
      if (j == abort_at) begin
        pend_l.ncols = (abort_at - 1) / 4;
        return;
      end
      if (!fetch_busy) break;
      step();
    end
    chk("busy_len", busy_cnt, 4 * COLUMNS);
  endtask

  task automatic display(input int npix);
    logic [4:0] e;
    pix_start = 1'b1;
    pix_en = 1'($urandom % 2);
    step();
    pix_start = 1'b0;
    pix_en = 1'b0;
    chk("start_hold_act", pix_active, last_active);
    chk("start_hold_col", pix_color, last_color);
    for (int p = 0; p < npix; p++) begin
      if ($urandom % 4 == 0) begin
        step();
        chk("hold_col", pix_color, last_color);
      end
      pix_en = 1'b1;
      step();
      pix_en = 1'b0;
      e = exp_px(p);
      last_active = e[4];
      last_color = e[3:0];
      chk("pix_active", pix_active, last_active);
      chk("pix_color", pix_color, last_color);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, fetch_busy, 0);
    chk({tag, "_taddr"}, text_addr, 0);
    chk({tag, "_faddr"}, font_addr, 0);
    chk({tag, "_color"}, pix_color, 0);
    chk({tag, "_active"}, pix_active, 0);
  endtask

  initial begin
    reset = 1'b1; line_start = 1'b0; vline = 8'd0; pix_start = 1'b0; pix_en = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      tram[i] = 16'($urandom);
      fram[i] = 8'($urandom);
    end
    tram[0] = 16'hF041;
    fram[11'h208] = 8'h81;
    tram[42] = 16'h3C5A;
    model_reset();
    step();
    step();
    chk_reset_state("reset");
    reset = 1'b0;
    step();

    // Directed first line, blank line, end-of-line saturation and restart.
    run_fetch(0, 0);
    run_fetch(200, 0);
    display(330);
    display(10);
    run_fetch(5, 0);
    display(20);

    // Addressing at row 1 glyph line 5, then abort and partial-bank display.
    run_fetch(13, 0);
    run_fetch(150, 0);
    display(NPIX);
    run_fetch(64, 50);
    run_fetch(8, 0);
    display(disp_l.ncols * 8);
    run_fetch(77, 0);
    display(NPIX);

    // Reset in the middle of a fetch.
    run_fetch(50, 30);
    reset = 1'b1;
    step();
    chk_reset_state("midreset");
    reset = 1'b0;
    model_reset();
    run_fetch(20, 0);
    display(16);
    run_fetch(33, 0);
    display(NPIX);

    for (int r = 0; r < 8; r++) begin
      run_fetch($urandom_range(0, 230), 0);
      display($urandom_range(1, 330));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
